// File: rtl/freq_gate_ctrl.sv
// Measurement controller for a gated frequency counter: drives the counter's gate, waits
// for its output register to settle, captures the count and converts it to packed BCD.
module freq_gate_ctrl #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int COUNT_W     = 28,
    parameter int DIGITS      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [COUNT_W-1:0]    count_in,
    output logic                  enable_out,
    output logic [COUNT_W-1:0]    bin_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    output logic                  overflow,
    output logic                  busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + 4;
    localparam int GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int IW    = $clog2(COUNT_W + 1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(COUNT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_SETTLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [GW-1:0]      r_gate_cnt;
    logic               r_settle;
    logic [IW-1:0]      r_iter_cnt;
    logic [COUNT_W-1:0] r_bin;
    logic [COUNT_W-1:0] r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic               r_lost;

    logic [SCR_W-1:0]   w_adj;
    logic [SCR_W-1:0]   w_next_scratch;
    logic               w_carry;
    logic               w_ovf;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] a;
        a = s;
        for (int d = 0; d < SCR_W / 4; d++) begin
            if (a[4*d +: 4] >= 4'd5) begin
                a[4*d +: 4] = a[4*d +: 4] + 4'd3;
            end
        end
        return a;
    endfunction

    assign w_adj          = dabble_adjust(r_scratch);
    assign w_next_scratch = {w_adj[SCR_W-2:0], r_shift[COUNT_W-1]};
    assign w_carry        = w_adj[SCR_W-1];
    // The extra top digit only ever becomes nonzero when the value exceeds DIGITS digits.
    assign w_ovf          = (r_scratch[SCR_W-1:BCD_W] != 4'd0) || r_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gate_cnt <= '0;
            r_settle   <= 1'b0;
            r_iter_cnt <= '0;
            r_bin      <= '0;
            r_shift    <= '0;
            r_scratch  <= '0;
            r_lost     <= 1'b0;
            enable_out <= 1'b0;
            bin_out    <= '0;
            bcd_out    <= '0;
            valid      <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    enable_out <= 1'b0;
                    busy       <= 1'b0;
                    if (run) begin
                        r_state    <= S_GATE;
                        r_gate_cnt <= '0;
                        enable_out <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_GATE: begin
                    if (!run) begin
                        r_state    <= S_IDLE;
                        enable_out <= 1'b0;
                        busy       <= 1'b0;
                    end else if (r_gate_cnt == GATE_LAST) begin
                        r_state    <= S_SETTLE;
                        r_gate_cnt <= '0;
                        r_settle   <= 1'b0;
                        enable_out <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GW'(1);
                    end
                end

                // Two idle cycles let the counter's output register catch the final count.
                S_SETTLE: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (r_settle) begin
                        r_state    <= S_CONVERT;
                        r_bin      <= count_in;
                        r_shift    <= count_in;
                        r_scratch  <= '0;
                        r_lost     <= 1'b0;
                        r_iter_cnt <= '0;
                    end else begin
                        r_settle <= 1'b1;
                    end
                end

                S_CONVERT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_scratch <= w_next_scratch;
                        r_lost    <= r_lost | w_carry;
                        r_shift   <= r_shift << 1;
                        if (r_iter_cnt == ITER_LAST) begin
                            r_state <= S_DONE;
                        end else begin
                            r_iter_cnt <= r_iter_cnt + IW'(1);
                        end
                    end
                end

                S_DONE: begin
                    bin_out  <= r_bin;
                    valid    <= 1'b1;
                    overflow <= w_ovf;
                    bcd_out  <= w_ovf ? {DIGITS{4'h9}} : r_scratch[BCD_W-1:0];
                    if (run) begin
                        r_state    <= S_GATE;
                        r_gate_cnt <= '0;
                        enable_out <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    enable_out <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Bench for freq_gate_ctrl: a measurement-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized run/rst/count traffic.
`timescale 1ns/1ps
module tb_freq_gate_ctrl;
    localparam int G      = 100;
    localparam int CW     = 28;
    localparam int D      = 8;
    localparam int PERIOD = G + 2 + CW + 1;
    localparam longint MAXDEC = 64'd99_999_999;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          use_cnt = 1'b0;
    logic [CW-1:0] count_drv = '0;
    logic [CW-1:0] count_in;
    logic          enable_out;
    logic [CW-1:0] bin_out;
    logic [4*D-1:0] bcd_out;
    logic          valid;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_gate_ctrl #(.GATE_CYCLES(G), .COUNT_W(CW), .DIGITS(D)) dut (
        .clk(clk), .rst(rst), .run(run), .count_in(count_in),
        .enable_out(enable_out), .bin_out(bin_out), .bcd_out(bcd_out),
        .valid(valid), .overflow(overflow), .busy(busy)
    );

    // Simple frequency counter: synchroniser, rising-edge count while gated, output register.
    logic          sig = 1'b0;
    logic [2:0]    c_sync = '0;
    logic [CW-1:0] c_cnt = '0;
    logic [CW-1:0] c_out = '0;
    always #50 sig = ~sig;
    always @(posedge clk) begin
        c_sync <= {c_sync[1:0], sig};
        if (enable_out) c_cnt <= c_cnt + CW'(c_sync[1] & ~c_sync[2]);
        else            c_cnt <= '0;
        c_out <= c_cnt;
    end
    assign count_in = use_cnt ? c_out : count_drv;

    function automatic logic [4*D-1:0] to_bcd(input longint v);
        logic [4*D-1:0] r;
        longint x;
        r = '0;
        x = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: a measurement is a start edge plus fixed offsets (capture, publish).
    bit            m_ok = 0;
    bit            m_active = 0;
    longint        m_edge = 0;
    longint        m_start = 0;
    logic [CW-1:0] m_cap = '0;
    logic          e_en = 0, e_busy = 0, e_valid = 0, e_ovf = 0;
    logic [CW-1:0] e_bin = '0;
    logic [4*D-1:0] e_bcd = '0;

    always @(posedge clk) begin : model
        longint off;
        m_edge++;
        e_valid = 1'b0;
        if (rst) begin
            m_ok = 1; m_active = 0;
            e_bin = '0; e_bcd = '0; e_ovf = 1'b0;
        end else if (!m_active) begin
            if (run) begin m_active = 1; m_start = m_edge; end
        end else begin
            off = m_edge - m_start;
            if (off <= G + CW + 2 && !run) begin
                m_active = 0;
            end else begin
                if (off == G + 2) m_cap = count_in;
                if (off == PERIOD) begin
                    e_valid = 1'b1;
                    e_bin   = m_cap;
                    e_ovf   = (longint'(m_cap) > MAXDEC);
                    e_bcd   = e_ovf ? {D{4'h9}} : to_bcd(longint'(m_cap));
                    if (run) m_start = m_edge;
                    else     m_active = 0;
                end
            end
        end
        off = m_edge - m_start;
        e_en   = m_active && (off < G);
        e_busy = m_active;
    end

    always @(negedge clk) begin
        if (m_ok) begin
            checks++;
            if (enable_out !== e_en || busy !== e_busy || valid !== e_valid ||
                overflow !== e_ovf || bin_out !== e_bin || bcd_out !== e_bcd) begin
                errors++;
                $display("FAIL model t=%0t actual en=%b busy=%b valid=%b ovf=%b bin=%0d bcd=%h required en=%b busy=%b valid=%b ovf=%b bin=%0d bcd=%h",
                         $time, enable_out, busy, valid, overflow, bin_out, bcd_out,
                         e_en, e_busy, e_valid, e_ovf, e_bin, e_bcd);
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (valid) begin n = i; break; end
        end
        if (n < 0) check("valid_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    enable_out, 0);
        check({tag, "_busy"},  busy,       0);
        check({tag, "_valid"}, valid,      0);
        check({tag, "_ovf"},   overflow,   0);
        check({tag, "_bin"},   bin_out,    0);
        check({tag, "_bcd"},   bcd_out,    0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, en_cnt, vcyc, n, vcount, low_left;
        bit seen;

        // Reset held with run high
        rst = 1'b1; run = 1'b1; count_drv = CW'(12345);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // First window timing and the 12345 conversion
        first = -1; en_cnt = 0; vcyc = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (valid) begin vcyc = i; break; end
            if (enable_out) begin
                en_cnt++;
                if (first < 0) first = i;
            end
        end
        check("first_enable_cycle", first, 1);
        check("gate_len", en_cnt, G);
        check("valid_latency", vcyc - first, PERIOD);
        check("bin_12345", bin_out, 12345);
        check("bcd_12345", bcd_out, 64'h0001_2345);
        check("ovf_12345", overflow, 0);
        count_drv = '0;
        @(negedge clk);
        check("valid_single", valid, 0);

        // Zero, just-overflow and largest in-range counts
        wait_valid(300, n);
        check("period_a", n, PERIOD - 1);
        check("bin_zero", bin_out, 0);
        check("bcd_zero", bcd_out, 0);
        check("ovf_zero", overflow, 0);
        count_drv = CW'(100_000_000);
        wait_valid(300, n);
        check("period_b", n, PERIOD);
        check("bin_1e8", bin_out, 100_000_000);
        check("bcd_1e8", bcd_out, 64'h9999_9999);
        check("ovf_1e8", overflow, 1);
        count_drv = CW'(99_999_999);
        wait_valid(300, n);
        check("bin_max", bin_out, 99_999_999);
        check("bcd_max", bcd_out, 64'h9999_9999);
        check("ovf_max", overflow, 0);

        // Abort at gate cycle 50, then restart with a full window
        repeat (50) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("abort_en", enable_out, 0);
        check("abort_busy", busy, 0);
        vcount = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("abort_no_valid", vcount, 0);
        check("abort_bcd_kept", bcd_out, 64'h9999_9999);
        check("abort_bin_kept", bin_out, 99_999_999);
        run = 1'b1;
        en_cnt = 0; seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (enable_out) begin en_cnt++; seen = 1; end
            else if (seen) break;
        end
        check("restart_gate_len", en_cnt, G);
        wait_valid(300, n);

        // Reset in the middle of the conversion
        repeat (G + 12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        @(negedge clk);
        check("midrst_restart", enable_out, 1);

        // Continuous run against the counter with a 1/10-clk input
        use_cnt = 1'b1;
        wait_valid(400, n);
        for (int k = 0; k < 5; k++) begin
            wait_valid(300, n);
            check("cnt_period", n, PERIOD);
            check("cnt_range", (bin_out >= 9 && bin_out <= 11), 1);
        end

        // Randomised run drops, resets and count values
        use_cnt = 1'b0;
        low_left = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 2999) == 0) rst = 1'b1;
            if (low_left > 0) begin
                low_left--;
                run = (low_left == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                run = 1'b0;
                low_left = $urandom_range(1, 20);
            end
            case ($urandom_range(0, 7))
                0:       count_drv = '0;
                1:       count_drv = CW'(99_999_999);
                2:       count_drv = CW'(100_000_000);
                3:       count_drv = '1;
                default: count_drv = CW'($urandom);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
